// File: rtl/multi_strobe_gen_pkg.sv
// Shared types and constants for the multi-channel strobe generator.
package multi_strobe_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic MODE_CONT  = 1'b0;
   localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/multi_strobe_gen_if.sv
// Control/config and strobe output bundle for multi_strobe_gen.
interface multi_strobe_gen_if #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned BURST_W = 16
);
   logic                    start_i;
   logic                    stop_i;
   logic                    mode_i;
   logic [CNT_W-1:0]        period_i;
   logic [BURST_W-1:0]      burst_len_i;
   logic [NUM_CH*CNT_W-1:0] phase_i;
   logic [NUM_CH-1:0]       en_o;
   logic                    busy_o;
   logic                    done_o;

   modport master (
      output start_i, stop_i, mode_i, period_i, burst_len_i, phase_i,
      input  en_o, busy_o, done_o
   );

   modport slave (
      input  start_i, stop_i, mode_i, period_i, burst_len_i, phase_i,
      output en_o, busy_o, done_o
   );
endinterface

// File: rtl/strobe_phase_cmp.sv
// Per-channel registered phase compare; produces a 1-cycle strobe when cnt hits phase.
module strobe_phase_cmp #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run_i,
   input  logic             run_clr_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic [CNT_W-1:0] phase_i,
   output logic             en_o
);
   logic en_q, en_d;

   always_comb begin
      en_d = 1'b0;
      if (!run_clr_i && run_i) en_d = (cnt_i == phase_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) en_q <= 1'b0;
      else        en_q <= en_d;
   end

   assign en_o = en_q;
endmodule

// File: rtl/multi_strobe_gen.sv
// Multi-channel periodic strobe generator: shared period counter, per-channel phase compare,
// continuous or N-period burst operation with start/stop control.
module multi_strobe_gen
   import multi_strobe_gen_pkg::*;
#(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned BURST_W = 16
) (
   input logic             clk,
   input logic             rst_n,
   multi_strobe_gen_if.slave bus
);
   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [BURST_W-1:0]      per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0]        period_q;
   logic [BURST_W-1:0]      burst_q;
   logic                    mode_q;
   logic [NUM_CH*CNT_W-1:0] phase_q;
   logic                    done_q, done_d;
   logic                    accept, wrap, last, cmp_run, run_clr;
   logic [NUM_CH-1:0]       en;

   always_comb begin
      accept = (state_q == IDLE) && bus.start_i && !bus.stop_i;
      wrap   = (cnt_q == period_q - CNT_W'(1));
      last   = wrap && (mode_q == MODE_BURST) && (per_cnt_q == burst_q - BURST_W'(1));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (bus.stop_i || last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      bus.en_o   = en;
      bus.busy_o = (state_q == RUN);
      bus.done_o = done_q;
   end

   // Counter datapath; per_cnt saturates so continuous mode can run indefinitely
   always_comb begin
      cnt_d     = cnt_q;
      per_cnt_d = per_cnt_q;
      done_d    = 1'b0;
      cmp_run   = 1'b0;
      run_clr   = 1'b0;
      if (state_q == RUN) begin
         if (bus.stop_i) begin
            cnt_d     = '0;
            per_cnt_d = '0;
            run_clr   = 1'b1;
         end else begin
            cmp_run = 1'b1;
            if (wrap) begin
               cnt_d = '0;
               if (last) begin
                  per_cnt_d = '0;
                  done_d    = 1'b1;
               end else if (per_cnt_q != '1) begin
                  per_cnt_d = per_cnt_q + BURST_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end else if (accept) begin
         cnt_d     = '0;
         per_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         per_cnt_q <= '0;
         done_q    <= 1'b0;
         period_q  <= '0;
         burst_q   <= '0;
         mode_q    <= 1'b0;
         phase_q   <= '0;
      end else begin
         cnt_q     <= cnt_d;
         per_cnt_q <= per_cnt_d;
         done_q    <= done_d;
         if (accept) begin
            period_q <= (bus.period_i == '0) ? CNT_W'(1) : bus.period_i;
            burst_q  <= (bus.burst_len_i == '0) ? BURST_W'(1) : bus.burst_len_i;
            mode_q   <= bus.mode_i;
            phase_q  <= bus.phase_i;
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      strobe_phase_cmp #(.CNT_W(CNT_W)) u_cmp (
         .clk       (clk),
         .rst_n     (rst_n),
         .run_i     (cmp_run),
         .run_clr_i (run_clr),
         .cnt_i     (cnt_q),
         .phase_i   (phase_q[k*CNT_W +: CNT_W]),
         .en_o      (en[k])
      );
   end
endmodule

// File: tb/tb_multi_strobe_gen.sv
// Scoreboard bench for multi_strobe_gen: directed scenarios plus random traffic vs a timeline model.
module tb_multi_strobe_gen;
   import multi_strobe_gen_pkg::*;

   localparam int unsigned NUM_CH  = 4;
   localparam int unsigned CNT_W   = 32;
   localparam int unsigned BURST_W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multi_strobe_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

   multi_strobe_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [NUM_CH-1:0] en;
      logic              busy;
      logic              done;
   } exp_t;

   exp_t        sb[$];
   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned cyc      = 0;

   // Configuration presented on the inputs
   logic               c_mode;
   logic [CNT_W-1:0]   c_period;
   logic [BURST_W-1:0] c_burst;
   logic [CNT_W-1:0]   c_ph[NUM_CH];

   // Reference model: a run is a timeline t = 0,1,2,... of compare cycles after the start edge
   bit     m_run  = 0;
   bit     m_mode = 0;
   longint m_t = 0, m_p = 1, m_b = 1;
   longint m_ph[NUM_CH];

   function automatic exp_t model_step(bit rst_ok, bit s, bit st);
      exp_t e;
      e.en = '0; e.busy = 1'b0; e.done = 1'b0;
      if (!rst_ok) begin
         m_run = 0;
         return e;
      end
      if (m_run) begin
         if (st) m_run = 0;
         else begin
            for (int k = 0; k < NUM_CH; k++)
               e.en[k] = (m_ph[k] < m_p) && ((m_t % m_p) == m_ph[k]);
            if (m_mode && (m_t == m_b * m_p - 1)) begin
               e.done = 1'b1;
               m_run  = 0;
            end else begin
               e.busy = 1'b1;
            end
            m_t++;
         end
      end else if (s && !st) begin
         m_p    = (c_period == 0) ? 1 : longint'(c_period);
         m_b    = (c_burst == 0) ? 1 : longint'(c_burst);
         m_mode = c_mode;
         for (int k = 0; k < NUM_CH; k++) m_ph[k] = longint'(c_ph[k]);
         m_t    = 0;
         m_run  = 1;
         e.busy = 1'b1;
      end
      return e;
   endfunction

   task automatic step(input bit s, input bit st, input bit r = 1'b1);
      @(negedge clk);
      rst_n           = r;
      bus.start_i     = s;
      bus.stop_i      = st;
      bus.mode_i      = c_mode;
      bus.period_i    = c_period;
      bus.burst_len_i = c_burst;
      for (int k = 0; k < NUM_CH; k++) bus.phase_i[k*CNT_W +: CNT_W] = c_ph[k];
      sb.push_back(model_step(r, s, st));
      if (!r) begin
         #1;
         checks++;
         if (bus.en_o !== '0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset t=%0t en/busy/done got %b/%b/%b required 0/0/0",
                     $time, bus.en_o, bus.busy_o, bus.done_o);
         end
      end
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic set_cfg(input logic m, input int unsigned p, input int unsigned b,
                          input int unsigned p0, input int unsigned p1,
                          input int unsigned p2, input int unsigned p3);
      c_mode   = m;
      c_period = CNT_W'(p);
      c_burst  = BURST_W'(b);
      c_ph[0]  = CNT_W'(p0);
      c_ph[1]  = CNT_W'(p1);
      c_ph[2]  = CNT_W'(p2);
      c_ph[3]  = CNT_W'(p3);
   endtask

   // Monitor: one expected output vector per clock edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.en_o !== e.en || bus.busy_o !== e.busy || bus.done_o !== e.done) begin
               failures++;
               $display("FAIL outputs cyc=%0d en/busy/done got %b/%b/%b required %b/%b/%b",
                        cyc, bus.en_o, bus.busy_o, bus.done_o, e.en, e.busy, e.done);
            end
         end
      end
   end

   initial begin
      set_cfg(MODE_CONT, 0, 0, 0, 0, 0, 0);
      bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.mode_i = 1'b0;
      bus.period_i = '0; bus.burst_len_i = '0; bus.phase_i = '0;

      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      run(3);

      // Staggered continuous strobes
      set_cfg(MODE_CONT, 4, 0, 0, 1, 2, 3);
      step(1'b1, 1'b0);
      run(14);
      step(1'b0, 1'b1);
      run(2);

      // Burst of three periods, done with the final strobe
      set_cfg(MODE_BURST, 10, 3, 9, 0, 5, 12);
      step(1'b1, 1'b0);
      run(34);

      // Stop mid-run, then restart with the first configuration
      set_cfg(MODE_CONT, 8, 0, 0, 3, 7, 2);
      step(1'b1, 1'b0);
      run(12);
      step(1'b0, 1'b1);
      run(2);
      set_cfg(MODE_CONT, 4, 0, 0, 1, 2, 3);
      step(1'b1, 1'b0);
      run(10);
      step(1'b0, 1'b1);

      // Period 0 behaves as 1; phase equal to period never fires
      set_cfg(MODE_CONT, 0, 0, 0, 1, 0, 3);
      step(1'b1, 1'b0);
      run(8);
      step(1'b0, 1'b1);
      set_cfg(MODE_CONT, 5, 0, 0, 5, 4, 7);
      step(1'b1, 1'b0);
      run(15);
      step(1'b0, 1'b1);

      // Simultaneous start and stop from idle
      set_cfg(MODE_CONT, 3, 0, 0, 1, 2, 0);
      step(1'b1, 1'b1);
      run(4);

      // Start while running with a different period is ignored
      set_cfg(MODE_CONT, 6, 0, 0, 2, 5, 1);
      step(1'b1, 1'b0);
      run(5);
      set_cfg(MODE_BURST, 3, 1, 1, 0, 2, 2);
      step(1'b1, 1'b0);
      run(15);
      step(1'b0, 1'b1);

      // Async reset in the middle of a burst
      set_cfg(MODE_BURST, 7, 4, 0, 3, 6, 2);
      step(1'b1, 1'b0);
      run(10);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      run(6);

      // Random traffic, inputs changing every cycle
      for (int i = 0; i < 1500; i++) begin
         c_mode   = 1'($urandom_range(0, 1));
         c_period = CNT_W'($urandom_range(0, 12));
         c_burst  = BURST_W'($urandom_range(0, 4));
         for (int k = 0; k < NUM_CH; k++) c_ph[k] = CNT_W'($urandom_range(0, 13));
         if ($urandom_range(0, 499) == 0)
            step(1'b0, 1'b0, 1'b0);
         else
            step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
      end
      run(4);

      @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
